// File: rtl/fifo_rr_drain_pkg.sv
// Shared types and helpers for the round-robin FWFT drain scheduler.
package fifo_rr_drain_pkg;

  typedef enum logic {
    ARB   = 1'b0,
    BURST = 1'b1
  } state_t;

  // A zero length still grants one word; oversize requests clamp to the maximum.
  function automatic int unsigned clamp_len(input int unsigned burst_len,
                                            input int unsigned max_burst);
    if (burst_len == 0) return 1;
    if (burst_len > max_burst) return max_burst;
    return burst_len;
  endfunction

endpackage

// File: rtl/fifo_fwft_rr_drain_rr_pick.sv
// Rotate-priority encoder: first asserted req at or after ptr, wrapping modulo NPORTS.
module rr_pick
  import fifo_rr_drain_pkg::*;
#(
  parameter int NPORTS = 4,
  parameter int PW     = $clog2(NPORTS)
) (
  input  logic [PW-1:0]     ptr,
  input  logic [NPORTS-1:0] req,
  output logic              found,
  output logic [PW-1:0]     idx
);

  logic [PW-1:0] cand;

  // Scan from the far end so the candidate nearest ptr is written last and wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      cand = PW'((int'(ptr) + i) % NPORTS);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_fwft_rr_drain.sv
// Round-robin drain of NPORTS FWFT FIFOs into one registered valid/ready stage.
// Optional per-port grant counters are built when FIFO_RR_DRAIN_STATS_EN is defined.
module fifo_fwft_rr_drain
  import fifo_rr_drain_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NPORTS    = 4,
  parameter int MAX_BURST = 16,
  parameter int PW        = $clog2(NPORTS),
  parameter int BW        = $clog2(MAX_BURST + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [BW-1:0]            burst_len,
  input  logic [NPORTS*WIDTH-1:0]  din,
  input  logic [NPORTS-1:0]        empty,
  output logic [NPORTS-1:0]        rden,
  output logic [WIDTH-1:0]         out_data,
  output logic [PW-1:0]            out_port,
  output logic                     out_valid,
`ifdef FIFO_RR_DRAIN_STATS_EN
  output logic [NPORTS*16-1:0]     grant_cnt,
`endif
  input  logic                     out_ready,
  output logic                     busy
);

  state_t            state, state_nxt;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     g;
  logic [BW-1:0]     len;
  logic [BW-1:0]     cnt;
  logic [BW-1:0]     cnt_inc;
  logic              pick_found;
  logic [PW-1:0]     pick_idx;
  logic              grant;
  logic              take;
  logic              burst_exit;
  logic [WIDTH-1:0]  din_a [NPORTS];

  always_comb begin
    for (int p = 0; p < NPORTS; p++) din_a[p] = din[p*WIDTH +: WIDTH];
  end

  rr_pick #(
    .NPORTS (NPORTS),
    .PW     (PW)
  ) u_pick (
    .ptr   (ptr),
    .req   (~empty),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign cnt_inc    = cnt + 1'b1;
  assign grant      = (state == ARB) && pick_found;
  // A dry FIFO cannot produce a take, so empty[g] alone marks the early exit.
  assign burst_exit = (take && (cnt_inc == len)) || ((state == BURST) && empty[g]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB:     if (pick_found) state_nxt = BURST;
      BURST:   if (burst_exit) state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  always_comb begin
    take = (state == BURST) && !empty[g] && (!out_valid || out_ready);
    rden = '0;
    if (rst_n) rden[g] = take;
    busy = (state == BURST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      g   <= '0;
      len <= '0;
      cnt <= '0;
    end else begin
      if (grant) begin
        g   <= pick_idx;
        len <= BW'(clamp_len(32'(burst_len), 32'(MAX_BURST)));
        cnt <= '0;
      end else if (take) begin
        cnt <= cnt_inc;
      end
      if (burst_exit) ptr <= (g == PW'(NPORTS - 1)) ? '0 : g + 1'b1;
    end
  end

  // Output stage: a take overwrites the held word in the same cycle it is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_port  <= '0;
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= din_a[g];
      out_port  <= g;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef FIFO_RR_DRAIN_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
    end else if (grant) begin
      for (int p = 0; p < NPORTS; p++) begin
        if ((pick_idx == PW'(p)) && (grant_cnt[p*16 +: 16] != 16'hFFFF))
          grant_cnt[p*16 +: 16] <= grant_cnt[p*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_fwft_rr_drain.sv
// Directed bench for fifo_fwft_rr_drain with queue-based FWFT FIFO models.
module tb_fifo_fwft_rr_drain;

  localparam int WIDTH     = 8;
  localparam int NPORTS    = 4;
  localparam int MAX_BURST = 16;
  localparam int PW        = 2;
  localparam int BW        = 5;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [BW-1:0]           burst_len;
  logic [NPORTS*WIDTH-1:0] din;
  logic [NPORTS-1:0]       empty;
  logic [NPORTS-1:0]       rden;
  logic [WIDTH-1:0]        out_data;
  logic [PW-1:0]           out_port;
  logic                    out_valid;
  logic                    out_ready;
  logic                    busy;
`ifdef FIFO_RR_DRAIN_STATS_EN
  logic [NPORTS*16-1:0]    grant_cnt;
`endif

  always #5 clk = ~clk;

  fifo_fwft_rr_drain #(
    .WIDTH     (WIDTH),
    .NPORTS    (NPORTS),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .burst_len (burst_len),
    .din       (din),
    .empty     (empty),
    .rden      (rden),
    .out_data  (out_data),
    .out_port  (out_port),
    .out_valid (out_valid),
`ifdef FIFO_RR_DRAIN_STATS_EN
    .grant_cnt (grant_cnt),
`endif
    .out_ready (out_ready),
    .busy      (busy)
  );

  logic [WIDTH-1:0] fq [NPORTS][$];
  logic [15:0]      acc_q[$];
  logic [15:0]      exp_q[$];
  int               n_chk = 0;
  int               n_bad = 0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] wd(input int p, input int k);
    return {3'(p), 5'(k)};
  endfunction

  task automatic refresh();
    for (int p = 0; p < NPORTS; p++) begin
      empty[p] = (fq[p].size() == 0);
      din[p*WIDTH +: WIDTH] = empty[p] ? '0 : fq[p][0];
    end
  endtask

  task automatic load(input int p, input int n, input int k0);
    for (int k = 0; k < n; k++) fq[p].push_back(wd(p, k0 + k));
    refresh();
  endtask

  task automatic push_exp(input int p, input int k);
    exp_q.push_back(16'({2'(p), wd(p, k)}));
  endtask

  // One clock: sample handshakes before the edge, advance FIFOs and log after it.
  task automatic cycle();
    logic [NPORTS-1:0] rd;
    logic              acc;
    logic [15:0]       ent;
    #1;
    rd  = rden;
    acc = out_valid && out_ready;
    ent = 16'({out_port, out_data});
    @(posedge clk);
    #1;
    if (acc) acc_q.push_back(ent);
    for (int p = 0; p < NPORTS; p++) begin
      if (rd[p]) begin
        chk_val("rden_nonempty", 32'(fq[p].size() != 0), 32'd1);
        if (fq[p].size() != 0) void'(fq[p].pop_front());
      end
    end
    refresh();
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int p = 0; p < NPORTS; p++) fq[p].delete();
    refresh();
    out_ready = 1'b1;
    run(2);
    rst_n = 1'b1;
    acc_q.delete();
    exp_q.delete();
  endtask

  task automatic cmp_log(input string tag);
    chk_val({tag, "_count"}, 32'(acc_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < acc_q.size()) chk_val(tag, 32'(acc_q[i]), 32'(exp_q[i]));
    end
  endtask

  bit ev[8] = '{0, 1, 1, 1, 1, 0, 1, 0};
  int ek[8] = '{0, 0, 1, 2, 3, 0, 4, 0};
  bit eb[8] = '{1, 1, 1, 1, 0, 1, 1, 0};

  initial begin
    rst_n     = 1'b0;
    burst_len = '0;
    out_ready = 1'b1;
    din       = '0;
    empty     = '1;
    #2;
    chk_val("rst_out_valid", 32'(out_valid), 32'd0);
    chk_val("rst_out_data",  32'(out_data),  32'd0);
    chk_val("rst_out_port",  32'(out_port),  32'd0);
    chk_val("rst_busy",      32'(busy),      32'd0);
    chk_val("rst_rden",      32'(rden),      32'd0);
    do_reset();

    // Idle: nothing to drain
    for (int i = 0; i < 20; i++) begin
      cycle();
      chk_val("idle_rden",  32'(rden),      32'd0);
      chk_val("idle_valid", 32'(out_valid), 32'd0);
      chk_val("idle_busy",  32'(busy),      32'd0);
    end

    // Single port, cycle-exact: 4-word burst, re-arbitration, then the 5th word
    burst_len = 5'd4;
    load(2, 5, 0);
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk_val("sp_busy",  32'(busy),      32'(eb[i]));
      chk_val("sp_valid", 32'(out_valid), 32'(ev[i]));
      if (ev[i]) begin
        chk_val("sp_data", 32'(out_data), 32'(wd(2, ek[i])));
        chk_val("sp_port", 32'(out_port), 32'd2);
      end
    end

    // Round-robin across all ports
    do_reset();
    burst_len = 5'd2;
    for (int p = 0; p < NPORTS; p++) load(p, 3, 0);
    for (int p = 0; p < NPORTS; p++) begin push_exp(p, 0); push_exp(p, 1); end
    for (int p = 0; p < NPORTS; p++) push_exp(p, 2);
    run(40);
    cmp_log("rr");

    // Backpressure mid-burst
    do_reset();
    burst_len = 5'd6;
    load(1, 8, 0);
    load(2, 1, 0);
    run(3);
    chk_val("bp_pre_data", 32'(out_data), 32'(wd(1, 1)));
    out_ready = 1'b0;
    #1;
    chk_val("bp_rden", 32'(rden), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk_val("bp_stall_rden",  32'(rden),      32'd0);
      chk_val("bp_stall_valid", 32'(out_valid), 32'd1);
      chk_val("bp_stall_data",  32'(out_data),  32'(wd(1, 1)));
    end
    out_ready = 1'b1;
    run(16);
    for (int k = 0; k < 6; k++) push_exp(1, k);
    push_exp(2, 0);
    push_exp(1, 6);
    push_exp(1, 7);
    cmp_log("bp");

    // burst_len = 0 behaves as 1
    do_reset();
    burst_len = 5'd0;
    load(0, 2, 0);
    load(1, 2, 0);
    run(16);
    push_exp(0, 0); push_exp(1, 0); push_exp(0, 1); push_exp(1, 1);
    cmp_log("len0");

    // burst_len = 31 clamps to MAX_BURST
    do_reset();
    burst_len = 5'd31;
    load(0, 20, 0);
    load(1, 2, 0);
    run(40);
    for (int k = 0; k < 16; k++) push_exp(0, k);
    push_exp(1, 0); push_exp(1, 1);
    for (int k = 16; k < 20; k++) push_exp(0, k);
    cmp_log("len31");

    // Asynchronous reset between edges, mid-burst
    do_reset();
    burst_len = 5'd4;
    load(3, 5, 0);
    run(3);
    chk_val("ar_pre_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_val("ar_valid", 32'(out_valid), 32'd0);
    chk_val("ar_rden",  32'(rden),      32'd0);
    chk_val("ar_busy",  32'(busy),      32'd0);
    chk_val("ar_data",  32'(out_data),  32'd0);
    load(0, 2, 0);
    #2;
    rst_n = 1'b1;
    acc_q.delete();
    run(14);
    push_exp(0, 0); push_exp(0, 1);
    push_exp(3, 2); push_exp(3, 3); push_exp(3, 4);
    cmp_log("ar");

`ifdef FIFO_RR_DRAIN_STATS_EN
    do_reset();
    burst_len = 5'd1;
    load(1, 3, 0);
    run(12);
    chk_val("stats_p1", 32'(grant_cnt[31:16]), 32'd3);
    chk_val("stats_p0", 32'(grant_cnt[15:0]),  32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
